// File: rtl/mult_share_pkg.sv
// Shared types, widths and the round-robin pick function for the
// mult_share_arb block.
//   state_e  : FSM state encoding (IDLE=0, BUSY=1, RESP=2)
//   OPW/RESW : operand and product widths
//   rr_pick  : first valid index at or after a pointer, wrapping modulo nreq
package mult_share_pkg;

  localparam int unsigned OPW    = 8;
  localparam int unsigned RESW   = 16;
  localparam int unsigned MAXREQ = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  // Scan nreq positions starting at ptr; only the first valid hit is kept.
  // Returns 0 when nothing is valid (caller qualifies with |valid).
  function automatic logic [2:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int unsigned       nreq);
    logic       found;
    logic [2:0] pos;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAXREQ; k++) begin
      pos = 3'((32'(ptr) + k) % nreq);
      if (!found && (k < nreq) && valid[pos]) begin
        rr_pick = pos;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mult_share_pipe.sv
// Registered 8x8 unsigned multiplier.
// Operands are captured on cap_en; the product then passes through
// MUL_LAT-1 free-running stages, so it is valid MUL_LAT cycles after capture
// (the caller registers it at the end of that cycle).
//   clk, rst   : clock, asynchronous active-high reset
//   cap_en     : load op1/op2 into the operand registers
//   op1, op2   : operands
//   prod       : unsigned 16-bit product
module mult_share_pipe
  import mult_share_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap_en,
  input  logic [OPW-1:0]  op1,
  input  logic [OPW-1:0]  op2,
  output logic [RESW-1:0] prod
);

  logic [OPW-1:0]  op1_q, op2_q;
  logic [RESW-1:0] prod_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (cap_en) begin
      op1_q <= op1;
      op2_q <= op2;
    end
  end

  assign prod_raw = RESW'(op1_q) * RESW'(op2_q);

  if (MUL_LAT > 1) begin : g_pipe
    localparam int unsigned DW = (MUL_LAT - 1) * RESW;
    logic [DW-1:0] stage_q;

    // Packed shift register: newest product enters at the bottom.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= (stage_q << RESW) | DW'(prod_raw);
      end
    end

    assign prod = stage_q[DW-1 -: RESW];
  end else begin : g_comb
    assign prod = prod_raw;
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one registered 8x8 multiplier among NREQ requesters.
// Round-robin arbitration (or fixed priority, lowest index wins, when
// MULT_SHARE_FIXED_PRIO_EN is defined), one operation in flight, result held
// until resp_valid & resp_ready.
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : per-requester handshake, req_ready one-hot
//   req_op1/req_op2      : packed operands, requester i at [8i+7:8i]
//   resp_valid/resp_ready: result handshake
//   resp_res/resp_id     : product and owning requester index
//   busy                 : high whenever the FSM is not idle
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned IDW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_op1,
  input  logic [NREQ*OPW-1:0] req_op2,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [RESW-1:0]     resp_res,
  output logic [IDW-1:0]      resp_id,
  output logic                busy
);

  localparam int unsigned CntW = 2;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  grant;
  logic            accept;
  logic [OPW-1:0]  g_op1, g_op2;
  logic [RESW-1:0] prod;

`ifdef MULT_SHARE_FIXED_PRIO_EN
  assign grant = IDW'(rr_pick(MAXREQ'(req_valid), 3'd0, NREQ));
`else
  logic [IDW-1:0] rr_ptr_q;
  assign grant = IDW'(rr_pick(MAXREQ'(req_valid), 3'(rr_ptr_q), NREQ));
`endif

  assign accept     = (state_q == StIdle) && (|req_valid);
  assign req_ready  = accept ? (NREQ'(1) << grant) : '0;
  assign resp_valid = (state_q == StResp);
  assign busy       = (state_q != StIdle);

  always_comb begin
    g_op1 = '0;
    g_op2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        g_op1 = req_op1[i*OPW +: OPW];
        g_op2 = req_op2[i*OPW +: OPW];
      end
    end
  end

  mult_share_pipe #(
    .MUL_LAT(MUL_LAT)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .cap_en(accept),
    .op1   (g_op1),
    .op2   (g_op2),
    .prod  (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      id_q     <= '0;
      resp_res <= '0;
      resp_id  <= '0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            id_q    <= grant;
            cnt_q   <= CntW'(MUL_LAT - 1);
            state_q <= StBusy;
`ifndef MULT_SHARE_FIXED_PRIO_EN
            rr_ptr_q <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
`endif
          end
        end
        StBusy: begin
          // Counter reaching zero marks the cycle the pipe output is valid.
          if (cnt_q == '0) begin
            resp_res <= prod;
            resp_id  <= id_q;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
